rename_unit: RTL and testbench
==============================

Name: rename_unit

Overview:
- Parametrised register-rename stage between instruction decode and dispatch.
- Maps architectural source and destination registers to physical registers using a speculative RAT, a retirement RAT (RRAT), a bit-vector free list and a busy table.
- Takes wakeups from the CDB and frees physical registers at commit.
- On flush, restores speculative state from the RRAT.

Parameters:
ARCH_REGS, 32, number of architectural registers; power of 2; register 0 hard-wired to zero.
PHYS_REGS, 64, number of physical registers; power of 2; must be greater than ARCH_REGS.
AREG_W, $clog2(ARCH_REGS), architectural index width (localparam).
PREG_W, $clog2(PHYS_REGS), physical index width (localparam).

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
inst_valid_i  in  1  decoded instruction present
rs1_addr_i  in  AREG_W  architectural source 1
rs2_addr_i  in  AREG_W  architectural source 2
rd_addr_i  in  AREG_W  architectural destination
rd_wen_i  in  1  instruction writes rd
ready_o  out  1  rename can accept this cycle
rename_valid_o  out  1  registered result valid
prs1_addr_o  out  PREG_W  physical source 1
prs2_addr_o  out  PREG_W  physical source 2
prd_addr_o  out  PREG_W  newly allocated destination
old_prd_addr_o  out  PREG_W  previous mapping of rd, freed at commit
prs1_ready_o  out  1  source 1 value already available
prs2_ready_o  out  1  source 2 value already available
cdb_en_i  in  1  CDB broadcast valid
cdb_preg_addr_i  in  PREG_W  physical register written on CDB
commit_en_i  in  1  instruction retiring with rd write
commit_rd_i  in  AREG_W  retiring rd
commit_prd_i  in  PREG_W  retiring prd
commit_old_prd_i  in  PREG_W  retiring old_prd, returned to free list
flush_i  in  1  mispredict/exception recovery

Behaviour:
Reset (reset_i low, async):
- RAT[i] = RRAT[i] = i.
- Free bits ARCH_REGS..PHYS_REGS-1 set; all others clear.
- Busy table all clear.
- All outputs 0, except ready_o, which follows its combinational definition.

Handshake:
- ready_o = !flush_i && (free vector non-zero).
- Accept = inst_valid_i && ready_o.

Latency and outputs:
- One cycle: outputs register on the edge after accept.
- rename_valid_o = 1 for exactly that cycle; otherwise 0.
- Outputs hold their values when not valid.

Allocation:
- Occurs when accept && rd_wen_i && rd_addr_i != 0.
- Pick the lowest-index set free bit P; clear it.
- Set busy[P]; RAT[rd] <= P.
- prd_addr_o = P; old_prd_addr_o = previous RAT[rd].
- If rd_wen_i = 0 or rd = 0: no allocation; prd_addr_o = 0 and old_prd_addr_o = 0.

Source lookup:
- prsN = RAT[rsN], using the pre-update RAT, so rs == rd in the same instruction reads the old mapping.
- prsN_ready = !busy[prsN] || (cdb_en_i && cdb_preg_addr_i == prsN), i.e. same-cycle CDB bypass.
- Physical register 0 is always ready.

CDB: cdb_en_i clears busy[cdb_preg_addr_i]. If it targets a register being allocated in the same cycle, the allocation's busy set wins.

Commit:
- RRAT[commit_rd_i] <= commit_prd_i.
- Free bit of commit_old_prd_i is set, unless it is 0.
- A freed register becomes allocatable from the next cycle, never in the same cycle.

Flush (synchronous, priority over accept):
- RAT <= next-state RRAT, which includes a same-cycle commit.
- Free vector <= complement of the set of registers referenced by the next-state RRAT.
- Busy table cleared.
- rename_valid_o <= 0.
- No allocation occurs in the flush cycle.

Invariants:
- Free-list population + ARCH_REGS = PHYS_REGS at quiescence with no instructions in flight.
- Physical register 0 is never allocated or freed.

Full condition: with the free vector zero, ready_o = 0 and the RAT does not change. A commit in that cycle makes ready_o = 1 on the next cycle.

Test Plan:
- Reset release, accept rs1=1, rs2=2, rd=3 -> next cycle: rename_valid_o=1, prs1=1, prs2=2, prd=32, old_prd=3, both ready=1.
- Back-to-back rd=5 then rs1=5 -> second result: prs1=33, prs1_ready=0. Then cdb_en_i with preg 33 in the lookup cycle -> prs1_ready=1.
- 32 allocations without commit -> ready_o=0, inputs ignored. Commit old_prd=3 -> ready_o=1 next cycle, next prd=3.
- rd=0 with rd_wen_i=1 -> prd=0, old_prd=0, free count unchanged.
- Rename rd=7 (prd=32, old=7), commit it, rename rd=7 again (prd=33), then flush -> RAT[7]=32. A following rs1=7 lookup gives prs1=32, ready=1. Free vector contains 7 and 33, not 32.
- Assert reset_i low mid-stream with rename_valid_o=1 -> outputs 0 immediately, RAT identity, free bits 32..63 only.

Source files
------------

// File: rtl/rename_unit_if.sv
// Purpose: decode-side, result, CDB, commit and flush signals of the rename stage.
// Ports: slave modport is the rename unit's view, master modport is the driver's view.
// Parameters must match the rename_unit instance they are connected to.
interface rename_unit_if #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
);
  localparam int AREG_W = $clog2(ARCH_REGS);
  localparam int PREG_W = $clog2(PHYS_REGS);

  // decode side
  logic              inst_valid_i;
  logic [AREG_W-1:0] rs1_addr_i;
  logic [AREG_W-1:0] rs2_addr_i;
  logic [AREG_W-1:0] rd_addr_i;
  logic              rd_wen_i;
  logic              ready_o;
  // registered rename result
  logic              rename_valid_o;
  logic [PREG_W-1:0] prs1_addr_o;
  logic [PREG_W-1:0] prs2_addr_o;
  logic [PREG_W-1:0] prd_addr_o;
  logic [PREG_W-1:0] old_prd_addr_o;
  logic              prs1_ready_o;
  logic              prs2_ready_o;
  // writeback broadcast
  logic              cdb_en_i;
  logic [PREG_W-1:0] cdb_preg_addr_i;
  // retirement
  logic              commit_en_i;
  logic [AREG_W-1:0] commit_rd_i;
  logic [PREG_W-1:0] commit_prd_i;
  logic [PREG_W-1:0] commit_old_prd_i;
  // recovery
  logic              flush_i;

  modport slave (
    input  inst_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_wen_i,
    output ready_o,
    output rename_valid_o, prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_addr_o,
    output prs1_ready_o, prs2_ready_o,
    input  cdb_en_i, cdb_preg_addr_i,
    input  commit_en_i, commit_rd_i, commit_prd_i, commit_old_prd_i,
    input  flush_i
  );

  modport master (
    output inst_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_wen_i,
    input  ready_o,
    input  rename_valid_o, prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_addr_o,
    input  prs1_ready_o, prs2_ready_o,
    output cdb_en_i, cdb_preg_addr_i,
    output commit_en_i, commit_rd_i, commit_prd_i, commit_old_prd_i,
    output flush_i
  );
endinterface

// File: rtl/rename_unit.sv
// Purpose: register rename (speculative RAT, retirement RAT, free bit-vector, busy table).
// Latency: one cycle from accept to rename_valid_o; results hold while not valid.
// Backpressure: ready_o drops when the free vector is empty or during flush.
// Ports: clk_i, reset_i (async active-low), bus (rename_unit_if.slave).
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input logic         clk_i,
  input logic         reset_i,
  rename_unit_if.slave bus
);
  localparam int AREG_W = $clog2(ARCH_REGS);
  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam logic [PHYS_REGS-1:0] FREE_RST =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PREG_W-1:0]    r_rat  [ARCH_REGS];
  logic [PREG_W-1:0]    r_rrat [ARCH_REGS];
  logic [PHYS_REGS-1:0] r_free;
  logic [PHYS_REGS-1:0] r_busy;

  logic              r_vld;
  logic [PREG_W-1:0] r_prs1, r_prs2, r_prd, r_old_prd;
  logic              r_prs1_rdy, r_prs2_rdy;

  logic                 w_ready, w_accept, w_alloc;
  logic [PREG_W-1:0]    w_pick;
  logic [PREG_W-1:0]    w_prs1, w_prs2;
  logic                 w_prs1_rdy, w_prs2_rdy;
  logic [PREG_W-1:0]    w_rrat_nxt [ARCH_REGS];
  logic [PHYS_REGS-1:0] w_rrat_ref;
  logic [PHYS_REGS-1:0] w_free_nxt;
  logic [PHYS_REGS-1:0] w_busy_nxt;

  assign w_ready  = !bus.flush_i && (|r_free);
  assign w_accept = bus.inst_valid_i && w_ready;
  assign w_alloc  = w_accept && bus.rd_wen_i && (bus.rd_addr_i != '0);

  // Lowest-index free register; scanning downwards lets the last hit win.
  always_comb begin
    w_pick = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (r_free[i]) w_pick = PREG_W'(i);
    end
  end

  // Lookups use the pre-update RAT, so rs == rd sees the previous mapping.
  // A same-cycle CDB write to the source counts as ready; preg 0 is always ready.
  assign w_prs1 = r_rat[bus.rs1_addr_i];
  assign w_prs2 = r_rat[bus.rs2_addr_i];
  assign w_prs1_rdy = (w_prs1 == '0) || !r_busy[w_prs1] ||
                      (bus.cdb_en_i && (bus.cdb_preg_addr_i == w_prs1));
  assign w_prs2_rdy = (w_prs2 == '0) || !r_busy[w_prs2] ||
                      (bus.cdb_en_i && (bus.cdb_preg_addr_i == w_prs2));

  // RRAT including this cycle's commit; flush restores from this view.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) w_rrat_nxt[i] = r_rrat[i];
    if (bus.commit_en_i && (bus.commit_rd_i != '0))
      w_rrat_nxt[bus.commit_rd_i] = bus.commit_prd_i;
  end

  always_comb begin
    w_rrat_ref = '0;
    for (int i = 0; i < ARCH_REGS; i++) w_rrat_ref[w_rrat_nxt[i]] = 1'b1;
  end

  // The pick comes from r_free, so a register freed by commit this cycle
  // is only allocatable from the next cycle.
  always_comb begin
    w_free_nxt = r_free;
    if (w_alloc) w_free_nxt[w_pick] = 1'b0;
    if (bus.commit_en_i && (bus.commit_old_prd_i != '0))
      w_free_nxt[bus.commit_old_prd_i] = 1'b1;
    if (bus.flush_i) w_free_nxt = ~w_rrat_ref;
  end

  // Allocation set is applied after the CDB clear so it wins on a collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.cdb_en_i) w_busy_nxt[bus.cdb_preg_addr_i] = 1'b0;
    if (w_alloc) w_busy_nxt[w_pick] = 1'b1;
    if (bus.flush_i) w_busy_nxt = '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rat[i]  <= PREG_W'(i);
        r_rrat[i] <= PREG_W'(i);
      end
      r_free     <= FREE_RST;
      r_busy     <= '0;
      r_vld      <= 1'b0;
      r_prs1     <= '0;
      r_prs2     <= '0;
      r_prd      <= '0;
      r_old_prd  <= '0;
      r_prs1_rdy <= 1'b0;
      r_prs2_rdy <= 1'b0;
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) r_rrat[i] <= w_rrat_nxt[i];
      if (bus.flush_i) begin
        for (int i = 0; i < ARCH_REGS; i++) r_rat[i] <= w_rrat_nxt[i];
      end else if (w_alloc) begin
        r_rat[bus.rd_addr_i] <= w_pick;
      end
      r_free <= w_free_nxt;
      r_busy <= w_busy_nxt;
      // accept is already low during flush, so valid drops there too
      r_vld  <= w_accept;
      if (w_accept) begin
        r_prs1     <= w_prs1;
        r_prs2     <= w_prs2;
        r_prs1_rdy <= w_prs1_rdy;
        r_prs2_rdy <= w_prs2_rdy;
        r_prd      <= w_alloc ? w_pick : '0;
        r_old_prd  <= w_alloc ? r_rat[bus.rd_addr_i] : '0;
      end
    end
  end

  assign bus.ready_o        = w_ready;
  assign bus.rename_valid_o = r_vld;
  assign bus.prs1_addr_o    = r_prs1;
  assign bus.prs2_addr_o    = r_prs2;
  assign bus.prd_addr_o     = r_prd;
  assign bus.old_prd_addr_o = r_old_prd;
  assign bus.prs1_ready_o   = r_prs1_rdy;
  assign bus.prs2_ready_o   = r_prs2_rdy;
endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;
  localparam int AR = 32;
  localparam int PR = 64;
  localparam int AW = $clog2(AR);
  localparam int PW = $clog2(PR);

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  rename_unit_if #(.ARCH_REGS(AR), .PHYS_REGS(PR)) bus ();

  rename_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: maps as int arrays, free list as an unordered queue, busy as bits.
  int m_rat  [AR];
  int m_rrat [AR];
  int m_free [$];
  bit m_busy [PR];
  bit e_vld, e_r1, e_r2;
  int e_prs1, e_prs2, e_prd, e_old;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < AR; a++) begin
      m_rat[a]  = a;
      m_rrat[a] = a;
    end
    m_free.delete();
    for (int p = AR; p < PR; p++) m_free.push_back(p);
    for (int p = 0; p < PR; p++) m_busy[p] = 1'b0;
    e_vld = 0; e_r1 = 0; e_r2 = 0;
    e_prs1 = 0; e_prs2 = 0; e_prd = 0; e_old = 0;
  endtask

  function automatic int pop_min();
    int best = 0;
    for (int k = 1; k < m_free.size(); k++)
      if (m_free[k] < m_free[best]) best = k;
    pop_min = m_free[best];
    m_free.delete(best);
  endfunction

  function automatic bit src_rdy(input int p);
    return (p == 0) || !m_busy[p] ||
           (bus.cdb_en_i && (int'(bus.cdb_preg_addr_i) == p));
  endfunction

  // Advance one clock; the model consumes the inputs sampled at that edge.
  task automatic tick();
    bit acc;
    int p, rd;
    @(posedge clk_i);
    if (reset_i) begin
      acc = bus.inst_valid_i && !bus.flush_i && (m_free.size() > 0);
      rd  = int'(bus.rd_addr_i);
      e_vld = acc;
      if (acc) begin
        e_prs1 = m_rat[bus.rs1_addr_i];
        e_prs2 = m_rat[bus.rs2_addr_i];
        e_r1 = src_rdy(e_prs1);
        e_r2 = src_rdy(e_prs2);
        e_prd = 0;
        e_old = 0;
      end
      if (bus.cdb_en_i) m_busy[bus.cdb_preg_addr_i] = 1'b0;
      if (acc && bus.rd_wen_i && rd != 0) begin
        p = pop_min();
        e_prd = p;
        e_old = m_rat[rd];
        m_rat[rd] = p;
        m_busy[p] = 1'b1;
      end
      if (bus.commit_en_i) begin
        if (bus.commit_rd_i != 0) m_rrat[bus.commit_rd_i] = int'(bus.commit_prd_i);
        if (bus.commit_old_prd_i != 0) m_free.push_back(int'(bus.commit_old_prd_i));
      end
      if (bus.flush_i) begin
        bit used;
        m_free.delete();
        for (int q = 0; q < PR; q++) begin
          used = 0;
          for (int a = 0; a < AR; a++) if (m_rrat[a] == q) used = 1;
          if (!used) m_free.push_back(q);
          m_busy[q] = 1'b0;
        end
        for (int a = 0; a < AR; a++) m_rat[a] = m_rrat[a];
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.inst_valid_i = 0; bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
    bus.rd_addr_i = '0; bus.rd_wen_i = 0;
    bus.cdb_en_i = 0; bus.cdb_preg_addr_i = '0;
    bus.commit_en_i = 0; bus.commit_rd_i = '0;
    bus.commit_prd_i = '0; bus.commit_old_prd_i = '0;
    bus.flush_i = 0;
  endtask

  task automatic inst(input int rs1, input int rs2, input int rd, input bit wen);
    idle();
    bus.inst_valid_i = 1;
    bus.rs1_addr_i = AW'(rs1);
    bus.rs2_addr_i = AW'(rs2);
    bus.rd_addr_i  = AW'(rd);
    bus.rd_wen_i   = wen;
  endtask

  task automatic commit(input int rd, input int prd, input int old);
    bus.commit_en_i = 1;
    bus.commit_rd_i = AW'(rd);
    bus.commit_prd_i = PW'(prd);
    bus.commit_old_prd_i = PW'(old);
  endtask

  task automatic do_reset();
    reset_i = 0;
    idle();
    model_reset();
    tick();
    tick();
    reset_i = 1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    chk("ready",    bus.ready_o, 32'(!bus.flush_i && (m_free.size() > 0)));
    chk("valid",    bus.rename_valid_o, 32'(e_vld));
    chk("prs1",     bus.prs1_addr_o, e_prs1);
    chk("prs2",     bus.prs2_addr_o, e_prs2);
    chk("prd",      bus.prd_addr_o, e_prd);
    chk("old_prd",  bus.old_prd_addr_o, e_old);
    chk("prs1_rdy", bus.prs1_ready_o, 32'(e_r1));
    chk("prs2_rdy", bus.prs2_ready_o, 32'(e_r2));
  end

  initial begin
    idle();
    do_reset();
    chk("rst_valid", bus.rename_valid_o, 0);
    chk("rst_ready", bus.ready_o, 1);

    // first rename after reset
    inst(1, 2, 3, 1); tick();
    chk("t1_valid", bus.rename_valid_o, 1);
    chk("t1_prs1", bus.prs1_addr_o, 1);
    chk("t1_prs2", bus.prs2_addr_o, 2);
    chk("t1_prd", bus.prd_addr_o, 32);
    chk("t1_old", bus.old_prd_addr_o, 3);
    chk("t1_rdy", {bus.prs1_ready_o, bus.prs2_ready_o}, 3);

    // dependent source, then CDB bypass in the lookup cycle
    inst(0, 0, 5, 1); tick();
    chk("t2_prd", bus.prd_addr_o, 33);
    chk("t2_old", bus.old_prd_addr_o, 5);
    inst(5, 0, 0, 0); tick();
    chk("t2_dep_prs1", bus.prs1_addr_o, 33);
    chk("t2_dep_rdy", bus.prs1_ready_o, 0);
    chk("t2_nowen_prd", bus.prd_addr_o, 0);
    inst(5, 0, 0, 0); bus.cdb_en_i = 1; bus.cdb_preg_addr_i = PW'(33); tick();
    chk("t2_bypass_rdy", bus.prs1_ready_o, 1);

    // rd = 0 does not allocate
    inst(0, 0, 0, 1); tick();
    chk("t3_prd", bus.prd_addr_o, 0);
    chk("t3_old", bus.old_prd_addr_o, 0);
    inst(0, 0, 6, 1); tick();
    chk("t3_next_prd", bus.prd_addr_o, 34);
    idle(); tick();
    chk("idle_valid", bus.rename_valid_o, 0);
    chk("idle_hold", bus.prd_addr_o, 34);

    // asynchronous reset with a valid result on the outputs
    inst(0, 0, 9, 1); tick();
    chk("pre_rst_valid", bus.rename_valid_o, 1);
    reset_i = 0; idle(); #1;
    chk("async_valid", bus.rename_valid_o, 0);
    chk("async_prd", bus.prd_addr_o, 0);
    model_reset();
    tick(); tick();
    reset_i = 1;
    inst(7, 9, 4, 1); tick();
    chk("t6_prs1", bus.prs1_addr_o, 7);
    chk("t6_prs2", bus.prs2_addr_o, 9);
    chk("t6_prd", bus.prd_addr_o, 32);
    chk("t6_old", bus.old_prd_addr_o, 4);

    // fill the free list: rd=i+1 receives preg 33+i
    for (int i = 0; i < 31; i++) begin
      inst(0, 0, i + 1, 1); tick();
    end
    idle(); #1;
    chk("full_ready", bus.ready_o, 0);
    inst(0, 0, 5, 1); tick();
    chk("full_ignored", bus.rename_valid_o, 0);
    inst(0, 0, 8, 1); commit(3, 35, 3); tick();
    chk("full_commit_no_acc", bus.rename_valid_o, 0);
    chk("full_ready_after", bus.ready_o, 1);
    inst(0, 0, 8, 1); tick();
    chk("full_reuse_prd", bus.prd_addr_o, 3);
    chk("full_reuse_old", bus.old_prd_addr_o, 40);

    // flush restores from the retirement map including a same-cycle commit
    idle();
    do_reset();
    inst(0, 0, 7, 1); tick();
    chk("t5_prd_a", bus.prd_addr_o, 32);
    chk("t5_old_a", bus.old_prd_addr_o, 7);
    inst(0, 0, 7, 1); commit(7, 32, 7); tick();
    chk("t5_prd_b", bus.prd_addr_o, 33);
    chk("t5_old_b", bus.old_prd_addr_o, 32);
    inst(0, 0, 12, 1); bus.flush_i = 1; #1;
    chk("flush_ready", bus.ready_o, 0);
    tick();
    chk("flush_valid", bus.rename_valid_o, 0);
    inst(7, 0, 10, 1); tick();
    chk("t5_prs1", bus.prs1_addr_o, 32);
    chk("t5_prs1_rdy", bus.prs1_ready_o, 1);
    chk("t5_prd_c", bus.prd_addr_o, 7);
    chk("t5_old_c", bus.old_prd_addr_o, 10);
    inst(0, 0, 11, 1); tick();
    chk("t5_prd_d", bus.prd_addr_o, 33);
    idle(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
